mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: DATAWIDTH, default 8, operand and product width in bits.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 multiply request; held high until done0 is seen.
REQ-005 a0, b0  input  DATAWIDTH each  requester 0 unsigned operands; valid while req0 is high.
REQ-006 req1  input  1  requester 1 multiply request; same rules as req0.
REQ-007 a1, b1  input  DATAWIDTH each  requester 1 unsigned operands.
REQ-008 done0, done1  output  1 each  one-cycle registered completion pulse to the granted requester.
REQ-009 prod  output  DATAWIDTH  registered product of the most recently completed operation.
REQ-010 busy  output  1  high while state is EXEC or DONE.
REQ-011 gnt_id  output  1  index of the requester owning the current or most recent operation.

Function
REQ-012 The block SHALL contain exactly one MUL instance (DATAWIDTH passed through), shared between both requesters via internal operand registers.
REQ-013 States SHALL be IDLE, EXEC and DONE, with IDLE entered on reset.
REQ-014 IDLE with req0 or req1 high at an edge SHALL latch the winner's operands and gnt_id, and go to EXEC.
REQ-015 EXEC SHALL go unconditionally to DONE at the next edge, registering the MUL product into prod and setting done[gnt_id] to 1.
REQ-016 Latency: request sampled at edge N yields done and the new prod during the cycle after edge N+1.
REQ-017 In DONE, the req of the just-served requester SHALL be ignored for that cycle.
REQ-018 DONE SHALL go to EXEC, latching the other requester, if that requester's req is high; otherwise DONE SHALL go to IDLE.
REQ-019 The block SHALL sustain a throughput of one operation per 2 cycles under continuous contention.
REQ-020 Arbitration SHALL be round-robin on simultaneous requests: grant the requester not granted last; a single request is granted immediately.
REQ-021 done0/done1 SHALL each be high for exactly one cycle per operation and never both at once.
REQ-022 Operand changes after the latching edge SHALL NOT affect the result.
REQ-023 A req dropped before grant SHALL be treated as withdrawn, with no done issued.
REQ-024 Arithmetic SHALL be unsigned; prod = (a*b) mod 2^DATAWIDTH.
REQ-025 prod and gnt_id SHALL hold their values until the next completion or grant.
REQ-026 A requester keeping req high after its done SHALL be treated as a new request, arbitrated from the next IDLE or DONE cycle.

Reset
REQ-027 On Rst at an edge, state SHALL become IDLE; prod, done0, done1, busy and gnt_id SHALL be 0; the last-granted pointer SHALL be 1, so req0 wins the first tie.
REQ-028 Rst during EXEC or DONE SHALL abort the operation with no done pulse, and Rst SHALL override any simultaneous req.

Configuration
REQ-029 With macro MUL_ARB_OVF_EN defined, the block SHALL provide output ovf (1 bit).
REQ-030 ovf SHALL be registered alongside prod, high when the full 2*DATAWIDTH unsigned product's upper DATAWIDTH bits are nonzero, and reset to 0.
REQ-031 Without MUL_ARB_OVF_EN, the block SHALL have no ovf port and no overflow logic, and the product SHALL be silently truncated.

Verification (DATAWIDTH=8)
REQ-032 Single request: req0=1, a0=3, b0=5 at edge N -> done0=1 and prod=15 during the cycle after N+1; busy=1 for 2 cycles.
REQ-033 Simultaneous request after reset: req0 (a0=2, b0=7) and req1 (a1=4, b1=9) held -> done0 with prod=14 first, then done1 with prod=36 two cycles later, no IDLE cycle between.
REQ-034 Fairness: both requesters re-request continuously for 6 operations -> done pulses alternate 0,1,0,1,0,1 and done0/done1 are never high together.
REQ-035 Overflow with MUL_ARB_OVF_EN: a0=16, b0=16 -> prod=0, ovf=1; a0=15, b0=17 -> prod=255, ovf=0.
REQ-036 Reset mid-operation: Rst asserted in EXEC -> no done pulse, prod=0, state IDLE; the next req1 is granted normally.
REQ-037 Operand stability: a0 changed from 3 to 9 one cycle after grant, with b0=5 -> prod=15.

Source files
------------

// File: rtl/mul_arbiter.sv
// Two-requester arbiter sharing one multiplier, round-robin on ties.
// Define MUL_ARB_OVF_EN to add the registered ovf output.
module mul_unit #(
  parameter int DATAWIDTH = 8,
  parameter int PW        = DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic [PW-1:0]        p_o
);
  assign p_o = PW'(a_i) * PW'(b_i);
endmodule

module mul_arbiter #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 req0,
  input  logic [DATAWIDTH-1:0] a0,
  input  logic [DATAWIDTH-1:0] b0,
  input  logic                 req1,
  input  logic [DATAWIDTH-1:0] a1,
  input  logic [DATAWIDTH-1:0] b1,
  output logic                 done0,
  output logic                 done1,
  output logic [DATAWIDTH-1:0] prod,
  output logic                 busy,
  output logic                 gnt_id
`ifdef MUL_ARB_OVF_EN
  ,
  output logic                 ovf
`endif
);

`ifdef MUL_ARB_OVF_EN
  localparam int PW = 2 * DATAWIDTH;
`else
  localparam int PW = DATAWIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] op_a_q, op_b_q;
  logic [DATAWIDTH-1:0] prod_q;
  logic                 gnt_q, last_q;
  logic                 done0_q, done1_q;
  logic [PW-1:0]        mul_p;

  logic other_req;
  logic grant_en;
  logic grant_sel;
  logic exec_fire;
  logic busy_c;

  mul_unit #(
    .DATAWIDTH(DATAWIDTH),
    .PW       (PW)
  ) u_mul (
    .a_i(op_a_q),
    .b_i(op_b_q),
    .p_o(mul_p)
  );

  // the requester just served is not eligible in DONE
  assign other_req = gnt_q ? req0 : req1;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0 || req1) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = other_req ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_en  = 1'b0;
    grant_sel = gnt_q;
    exec_fire = 1'b0;
    busy_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_en  = req0 | req1;
        grant_sel = (req0 && req1) ? ~last_q : req1;
      end
      EXEC: begin
        exec_fire = 1'b1;
        busy_c    = 1'b1;
      end
      DONE: begin
        busy_c    = 1'b1;
        grant_en  = other_req;
        grant_sel = ~gnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      prod_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      if (grant_en) begin
        op_a_q <= grant_sel ? a1 : a0;
        op_b_q <= grant_sel ? b1 : b0;
        gnt_q  <= grant_sel;
        last_q <= grant_sel;
      end
      if (exec_fire) prod_q <= mul_p[DATAWIDTH-1:0];
      done0_q <= exec_fire & ~gnt_q;
      done1_q <= exec_fire & gnt_q;
    end
  end

`ifdef MUL_ARB_OVF_EN
  logic ovf_q;

  always_ff @(posedge Clk) begin
    if (Rst)            ovf_q <= 1'b0;
    else if (exec_fire) ovf_q <= |mul_p[PW-1:DATAWIDTH];
  end

  assign ovf = ovf_q;
`endif

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign prod   = prod_q;
  assign gnt_id = gnt_q;
  assign busy   = busy_c;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: per-requester expected queues,
// negedge monitor pops and compares on every done pulse.
module tb_mul_arbiter;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [W-1:0] prod;
  logic         done0, done1, busy, gnt_id;
`ifdef MUL_ARB_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] p;
    logic         v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ord_q[$];
  int   cyc_q[$];
  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;

  logic [W-1:0] fa0[3] = '{8'd1, 8'd5, 8'd10};
  logic [W-1:0] fb0[3] = '{8'd1, 8'd6, 8'd20};
  logic [W-1:0] fp0[3] = '{8'd1, 8'd30, 8'd200};
  logic [W-1:0] fa1[3] = '{8'd2, 8'd7, 8'd12};
  logic [W-1:0] fb1[3] = '{8'd3, 8'd7, 8'd12};
  logic [W-1:0] fp1[3] = '{8'd6, 8'd49, 8'd144};
  int           fexp[6] = '{0, 1, 0, 1, 0, 1};

  always #5 Clk = ~Clk;

  mul_arbiter #(.DATAWIDTH(W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .done0 (done0),
    .done1 (done1),
    .prod  (prod),
    .busy  (busy),
    .gnt_id(gnt_id)
`ifdef MUL_ARB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic take(int id);
    exp_t e;
    ord_q.push_back(id);
    cyc_q.push_back(cyc);
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      checks++;
      errs++;
      $display("FAIL done%0d_unexpected: got pulse expected none", id);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    chk($sformatf("prod_r%0d", id), int'(prod), int'(e.p));
    chk($sformatf("gnt_id_r%0d", id), int'(gnt_id), id);
`ifdef MUL_ARB_OVF_EN
    chk($sformatf("ovf_r%0d", id), int'(ovf), int'(e.v));
`endif
  endtask

  always @(negedge Clk) begin
    cyc++;
    if (done0 || done1) begin
      chk("done_exclusive", int'(done0 & done1), 0);
      if (done0) take(0);
      if (done1) take(1);
    end
  end

  task automatic drive(int id, logic r, logic [W-1:0] a, logic [W-1:0] b);
    if (id == 0) begin
      req0 = r; a0 = a; b0 = b;
    end else begin
      req1 = r; a1 = a; b1 = b;
    end
  endtask

  // issue one op, hold req until done, then drop req unless keep is set
  task automatic run(int id, logic [W-1:0] a, logic [W-1:0] b,
                     logic [W-1:0] p, logic v, int new_a, bit keep);
    exp_t e;
    bit   ok;
    e.p = p;
    e.v = v;
    drive(id, 1'b1, a, b);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    if (new_a >= 0) begin
      @(posedge Clk);
      #1;
      if (id == 0) a0 = W'(new_a);
      else         a1 = W'(new_a);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clk);
      ok = (id == 0) ? done0 : done1;
    end
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL timeout_r%0d: got no done expected done", id);
    end
    @(posedge Clk);
    #1;
    if (!keep) begin
      if (id == 0) req0 = 1'b0;
      else         req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    ord_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();
    @(negedge Clk);
    chk("rst_prod", int'(prod), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_gnt", int'(gnt_id), 0);
`ifdef MUL_ARB_OVF_EN
    chk("rst_ovf", int'(ovf), 0);
`endif

    // single request, latency and busy window
    drive(0, 1'b1, 8'd3, 8'd5);
    q0.push_back('{8'd15, 1'b0});
    @(negedge Clk);
    chk("single_busy_exec", int'(busy), 1);
    chk("single_done_exec", int'(done0), 0);
    @(negedge Clk);
    chk("single_busy_done", int'(busy), 1);
    chk("single_done0", int'(done0), 1);
    @(posedge Clk);
    #1 req0 = 1'b0;
    @(negedge Clk);
    chk("single_busy_idle", int'(busy), 0);
    chk("single_prod_hold", int'(prod), 15);

    // simultaneous request after reset: req0 first, back to back
    do_reset();
    fork
      run(0, 8'd2, 8'd7, 8'd14, 1'b0, -1, 1'b0);
      run(1, 8'd4, 8'd9, 8'd36, 1'b0, -1, 1'b0);
    join
    chk("tie_count", ord_q.size(), 2);
    if (ord_q.size() == 2) begin
      chk("tie_first", ord_q[0], 0);
      chk("tie_second", ord_q[1], 1);
      chk("tie_gap", cyc_q[1] - cyc_q[0], 2);
    end

    // continuous contention alternates
    do_reset();
    fork
      for (int k = 0; k < 3; k++)
        run(0, fa0[k], fb0[k], fp0[k], 1'b0, -1, k < 2);
      for (int k = 0; k < 3; k++)
        run(1, fa1[k], fb1[k], fp1[k], 1'b0, -1, k < 2);
    join
    chk("fair_count", ord_q.size(), 6);
    if (ord_q.size() == 6)
      for (int k = 0; k < 6; k++)
        chk($sformatf("fair_order%0d", k), ord_q[k], fexp[k]);
    if (cyc_q.size() == 6)
      chk("fair_rate", cyc_q[5] - cyc_q[0], 10);

    // operand change after latching edge is ignored
    run(0, 8'd3, 8'd5, 8'd15, 1'b0, 9, 1'b0);

    // truncation and overflow flag
    run(0, 8'd16, 8'd16, 8'd0, 1'b1, -1, 1'b0);
    run(0, 8'd15, 8'd17, 8'd255, 1'b0, -1, 1'b0);

    // held req after done becomes a fresh request
    run(0, 8'd6, 8'd6, 8'd36, 1'b0, -1, 1'b1);
    run(0, 8'd7, 8'd8, 8'd56, 1'b0, -1, 1'b0);

    // reset in EXEC aborts with no done
    drive(1, 1'b1, 8'd5, 8'd5);
    @(posedge Clk);
    #1;
    chk("abort_in_exec", int'(busy), 1);
    Rst = 1'b1;
    req1 = 1'b0;
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("abort_prod", int'(prod), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_gnt", int'(gnt_id), 0);
    run(1, 8'd6, 8'd7, 8'd42, 1'b0, -1, 1'b0);
    chk("after_abort_gnt", int'(gnt_id), 1);

    repeat (3) @(negedge Clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end
endmodule
